// File: rtl/cci_mpf_shim_pipe_buf_pkg.sv
// Shared helpers for the MPF pipe buffer: occupancy sizing and the
// elaboration-time legality check of the buffering parameters.
package cci_mpf_shim_pipe_buf_pkg;

  // Occupancy/pointer width: one extra bit so a full FIFO is distinguishable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  function automatic bit params_legal(input int skid_depth, input int n_tx,
                                      input int n_rx, input int afu_slack);
    bit ok;
    ok = 1'b1;
    if (skid_depth < 32'sd2) begin
      ok = 1'b0;
    end else if ((skid_depth & (skid_depth - 32'sd1)) != 32'sd0) begin
      ok = 1'b0;
    end else if (n_tx < 32'sd0 || n_tx > 32'sd4 || n_rx < 32'sd0 || n_rx > 32'sd4) begin
      ok = 1'b0;
    end else if (skid_depth < afu_slack + n_tx + 32'sd2) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/cci_mpf_shim_pipe_buf_chan.sv
// One request channel: register stages, skid FIFO with empty bypass, pulsed
// output register, occupancy counter, almost-full, high-water mark, overflow.
module cci_mpf_shim_pipe_buf_chan
  import cci_mpf_shim_pipe_buf_pkg::*;
#(
  parameter int TX_WIDTH    = 600,
  parameter int N_TX_STAGES = 2,
  parameter int SKID_DEPTH  = 16,
  parameter int AFU_SLACK   = 8,
  parameter int OCC_W       = occ_width(SKID_DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tx_valid_i,
  input  logic [TX_WIDTH-1:0] tx_pkt_i,
  output logic                almost_full_o,
  output logic                fiu_valid_o,
  output logic [TX_WIDTH-1:0] fiu_pkt_o,
  input  logic                fiu_almost_full_i,
  output logic [OCC_W-1:0]    hwm_o,
  output logic                overflow_o
);
  localparam int AW = $clog2(SKID_DEPTH);
  localparam logic [OCC_W-1:0] AF_THRESH = OCC_W'(SKID_DEPTH - AFU_SLACK);

  logic                stg_vld_s;
  logic [TX_WIDTH-1:0] stg_pkt_s;

  if (N_TX_STAGES == 0) begin : g_no_stg
    assign stg_vld_s = tx_valid_i;
    assign stg_pkt_s = tx_pkt_i;
  end else begin : g_stg
    logic [N_TX_STAGES-1:0] vld_q;
    logic [TX_WIDTH-1:0]    pkt_q [N_TX_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= tx_valid_i;
        for (int k = 1; k < N_TX_STAGES; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      pkt_q[0] <= tx_pkt_i;
      for (int k = 1; k < N_TX_STAGES; k++) pkt_q[k] <= pkt_q[k-1];
    end

    assign stg_vld_s = vld_q[N_TX_STAGES-1];
    assign stg_pkt_s = pkt_q[N_TX_STAGES-1];
  end

  logic [TX_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [OCC_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    cnt_q, cnt_d, hwm_q, hwm_d;
  logic                out_vld_q, out_vld_d, af_q, af_d, ovf_q, ovf_d;
  logic [TX_WIDTH-1:0] out_pkt_q, out_pkt_d;
  logic                empty_s, full_s, pop_s, bypass_s, wr_req_s, wr_en_s, drop_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // An empty FIFO lets the last stage feed the output register directly,
  // giving N_TX_STAGES+1 minimum latency while keeping the output registered.
  always_comb begin
    pop_s     = 1'b0;
    bypass_s  = 1'b0;
    out_vld_d = 1'b0;
    out_pkt_d = out_pkt_q;
    if (fiu_almost_full_i) begin
      out_vld_d = 1'b0;
    end else if (!empty_s) begin
      pop_s     = 1'b1;
      out_vld_d = 1'b1;
      out_pkt_d = mem_q[rd_ptr_q[AW-1:0]];
    end else if (stg_vld_s) begin
      bypass_s  = 1'b1;
      out_vld_d = 1'b1;
      out_pkt_d = stg_pkt_s;
    end else begin
      out_vld_d = 1'b0;
    end
    wr_req_s = stg_vld_s & ~bypass_s;
    drop_s   = wr_req_s & full_s & ~pop_s;
    wr_en_s  = wr_req_s & ~drop_s;
    wr_ptr_d = wr_en_s ? wr_ptr_q + OCC_W'(1'b1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + OCC_W'(1'b1) : rd_ptr_q;
    // A dropped packet leaves the count so occupancy never drifts.
    cnt_d    = cnt_q + OCC_W'(tx_valid_i) - OCC_W'(out_vld_q) - OCC_W'(drop_s);
    af_d     = (cnt_d >= AF_THRESH);
    hwm_d    = (cnt_q > hwm_q) ? cnt_q : hwm_q;
    ovf_d    = ovf_q | drop_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      hwm_q     <= '0;
      out_vld_q <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      hwm_q     <= hwm_d;
      out_vld_q <= out_vld_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    out_pkt_q <= out_pkt_d;
    if (wr_en_s) mem_q[wr_ptr_q[AW-1:0]] <= stg_pkt_s;
  end

  assign almost_full_o = af_q;
  assign fiu_valid_o   = out_vld_q;
  assign fiu_pkt_o     = out_pkt_q;
  assign hwm_o         = hwm_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/cci_mpf_shim_pipe_buf.sv
// Timing/buffering stage between MPF shims: N buffered request channels with
// local almost-full regeneration, plus a fixed-delay response path.
module cci_mpf_shim_pipe_buf
  import cci_mpf_shim_pipe_buf_pkg::*;
#(
  parameter int N_CHANNELS  = 2,
  parameter int TX_WIDTH    = 600,
  parameter int RX_WIDTH    = 600,
  parameter int N_TX_STAGES = 2,
  parameter int N_RX_STAGES = 1,
  parameter int SKID_DEPTH  = 16,
  parameter int AFU_SLACK   = 8,
  localparam int OCC_W      = occ_width(SKID_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_CHANNELS-1:0]          afu_tx_valid,
  input  logic [N_CHANNELS*TX_WIDTH-1:0] afu_tx_pkt,
  output logic [N_CHANNELS-1:0]          afu_almost_full,
  output logic [N_CHANNELS-1:0]          fiu_tx_valid,
  output logic [N_CHANNELS*TX_WIDTH-1:0] fiu_tx_pkt,
  input  logic [N_CHANNELS-1:0]          fiu_almost_full,
  input  logic [N_CHANNELS-1:0]          fiu_rx_valid,
  input  logic [N_CHANNELS*RX_WIDTH-1:0] fiu_rx_pkt,
  output logic [N_CHANNELS-1:0]          afu_rx_valid,
  output logic [N_CHANNELS*RX_WIDTH-1:0] afu_rx_pkt,
  output logic [N_CHANNELS*OCC_W-1:0]    hwm,
  output logic [N_CHANNELS-1:0]          error_overflow
);

  if (!params_legal(SKID_DEPTH, N_TX_STAGES, N_RX_STAGES, AFU_SLACK)) begin : g_bad_params
    $error("cci_mpf_shim_pipe_buf: illegal SKID_DEPTH/N_TX_STAGES/N_RX_STAGES/AFU_SLACK");
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
    cci_mpf_shim_pipe_buf_chan #(
      .TX_WIDTH    (TX_WIDTH),
      .N_TX_STAGES (N_TX_STAGES),
      .SKID_DEPTH  (SKID_DEPTH),
      .AFU_SLACK   (AFU_SLACK),
      .OCC_W       (OCC_W)
    ) u_chan (
      .clk               (clk),
      .reset_n           (reset_n),
      .tx_valid_i        (afu_tx_valid[c]),
      .tx_pkt_i          (afu_tx_pkt[c*TX_WIDTH +: TX_WIDTH]),
      .almost_full_o     (afu_almost_full[c]),
      .fiu_valid_o       (fiu_tx_valid[c]),
      .fiu_pkt_o         (fiu_tx_pkt[c*TX_WIDTH +: TX_WIDTH]),
      .fiu_almost_full_i (fiu_almost_full[c]),
      .hwm_o             (hwm[c*OCC_W +: OCC_W]),
      .overflow_o        (error_overflow[c])
    );
  end

  if (N_RX_STAGES == 0) begin : g_rx_wire
    assign afu_rx_valid = fiu_rx_valid;
    assign afu_rx_pkt   = fiu_rx_pkt;
  end else begin : g_rx_pipe
    logic [N_CHANNELS-1:0]          vld_q [N_RX_STAGES];
    logic [N_CHANNELS*RX_WIDTH-1:0] pkt_q [N_RX_STAGES];

    // Response valids shift with reset so a reset flushes in-flight responses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < N_RX_STAGES; k++) vld_q[k] <= '0;
      end else begin
        vld_q[0] <= fiu_rx_valid;
        for (int k = 1; k < N_RX_STAGES; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      pkt_q[0] <= fiu_rx_pkt;
      for (int k = 1; k < N_RX_STAGES; k++) pkt_q[k] <= pkt_q[k-1];
    end

    assign afu_rx_valid = vld_q[N_RX_STAGES-1];
    assign afu_rx_pkt   = pkt_q[N_RX_STAGES-1];
  end

endmodule

// File: tb/tb_cci_mpf_shim_pipe_buf.sv
// Directed self-checking bench for cci_mpf_shim_pipe_buf (N_RX_STAGES=3).
module tb_cci_mpf_shim_pipe_buf;
  localparam int NCH = 2;
  localparam int TXW = 64;
  localparam int RXW = 48;
  localparam int OW  = 5;

  logic               clk, reset_n;
  logic [NCH-1:0]     afu_tx_valid, afu_almost_full, fiu_tx_valid, fiu_almost_full;
  logic [NCH-1:0]     fiu_rx_valid, afu_rx_valid, error_overflow;
  logic [NCH*TXW-1:0] afu_tx_pkt, fiu_tx_pkt;
  logic [NCH*RXW-1:0] fiu_rx_pkt, afu_rx_pkt;
  logic [NCH*OW-1:0]  hwm;

  int n_vec = 0;
  int n_err = 0;

  cci_mpf_shim_pipe_buf #(
    .N_CHANNELS(NCH), .TX_WIDTH(TXW), .RX_WIDTH(RXW), .N_TX_STAGES(2),
    .N_RX_STAGES(3), .SKID_DEPTH(16), .AFU_SLACK(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .afu_tx_valid(afu_tx_valid), .afu_tx_pkt(afu_tx_pkt),
    .afu_almost_full(afu_almost_full),
    .fiu_tx_valid(fiu_tx_valid), .fiu_tx_pkt(fiu_tx_pkt),
    .fiu_almost_full(fiu_almost_full),
    .fiu_rx_valid(fiu_rx_valid), .fiu_rx_pkt(fiu_rx_pkt),
    .afu_rx_valid(afu_rx_valid), .afu_rx_pkt(afu_rx_pkt),
    .hwm(hwm), .error_overflow(error_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hwm_of(input int ch);
    return 64'(hwm[ch*OW +: OW]);
  endfunction

  // One c0 request; must appear exactly once, 3 cycles after acceptance.
  task automatic single_c0(input string tag, input logic [63:0] pkt);
    afu_tx_valid[0] = 1'b1;
    afu_tx_pkt[0 +: TXW] = pkt;
    tick();
    afu_tx_valid[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_valid"}, 64'(fiu_tx_valid[0]), (k == 3) ? 64'd1 : 64'd0);
      if (k == 3) check({tag, "_pkt"}, fiu_tx_pkt[0 +: TXW], pkt);
      tick();
    end
  endtask

  // c1 burst with FIU blocked, then release and check in-order drain.
  task automatic burst_c1(input string tag, input int n, input logic [63:0] base);
    fiu_almost_full[1] = 1'b1;
    for (int i = 0; i < n; i++) begin
      afu_tx_valid[1] = 1'b1;
      afu_tx_pkt[TXW +: TXW] = base + 64'(i);
      check({tag, "_afu_af"}, 64'(afu_almost_full[1]), 64'(i >= 8));
      tick();
    end
    afu_tx_valid[1] = 1'b0;
    repeat (4) tick();
    check({tag, "_af_held"}, 64'(afu_almost_full[1]), 64'd1);
    check({tag, "_ovf"}, 64'(error_overflow), (n > 16) ? 64'd2 : 64'd0);
    check({tag, "_hwm1"}, hwm_of(1), 64'(n));
    fiu_almost_full[1] = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check({tag, "_drain_valid"}, 64'(fiu_tx_valid[1]), 64'(k <= 16));
      if (k <= 16) check({tag, "_drain_pkt"}, fiu_tx_pkt[TXW +: TXW], base + 64'(k - 1));
    end
    check({tag, "_af_clear"}, 64'(afu_almost_full[1]), 64'd0);
    check({tag, "_ovf_sticky"}, 64'(error_overflow), (n > 16) ? 64'd2 : 64'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    afu_tx_valid = '0;
    afu_tx_pkt = '0;
    fiu_almost_full = '0;
    fiu_rx_valid = '0;
    fiu_rx_pkt = '0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    check("rst_fiu_tx_valid", 64'(fiu_tx_valid), 64'd0);
    check("rst_afu_af", 64'(afu_almost_full), 64'd0);
    check("rst_afu_rx_valid", 64'(afu_rx_valid), 64'd0);
    check("rst_hwm", 64'(hwm), 64'd0);
    check("rst_ovf", 64'(error_overflow), 64'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    single_c0("t1", 64'hC0FF_EE00_0000_0001);
    check("t1_hwm0", hwm_of(0), 64'd1);

    burst_c1("t2", 16, 64'h0000_0000_0000_B200);
    burst_c1("t3", 17, 64'h0000_0000_0000_B300);
    single_c0("t3_c0", 64'h1234_5678_9ABC_DEF0);
    check("t3_c0_ovf", 64'(error_overflow), 64'd2);

    for (int k = 0; k < 14; k++) begin
      fiu_rx_valid[0] = (k == 5) || (k == 6) || (k == 9);
      fiu_rx_valid[1] = (k == 7);
      fiu_rx_pkt[0 +: RXW] = 48'hA0_0000 + 48'(k);
      fiu_rx_pkt[RXW +: RXW] = 48'hB0_0000 + 48'(k);
      check("t4_rx0_valid", 64'(afu_rx_valid[0]), 64'((k == 8) || (k == 9) || (k == 12)));
      check("t4_rx1_valid", 64'(afu_rx_valid[1]), 64'(k == 10));
      if ((k == 8) || (k == 9) || (k == 12))
        check("t4_rx0_pkt", 64'(afu_rx_pkt[0 +: RXW]), 64'h00A0_0000 + 64'(k - 3));
      if (k == 10) check("t4_rx1_pkt", 64'(afu_rx_pkt[RXW +: RXW]), 64'h00B0_0007);
      tick();
    end
    fiu_rx_valid = '0;

    for (int i = 0; i < 100; i++) begin
      afu_tx_valid[0] = 1'b1;
      afu_tx_pkt[0 +: TXW] = 64'hD500 + 64'(i);
      check("t5_afu_af", 64'(afu_almost_full[0]), 64'd0);
      if (i >= 3) begin
        check("t5_valid", 64'(fiu_tx_valid[0]), 64'd1);
        check("t5_pkt", fiu_tx_pkt[0 +: TXW], 64'hD500 + 64'(i - 3));
      end
      tick();
    end
    afu_tx_valid = '0;
    check("t5_hwm0", hwm_of(0), 64'd3);
    repeat (4) tick();

    fiu_almost_full[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      afu_tx_valid[0] = 1'b1;
      afu_tx_pkt[0 +: TXW] = 64'hE600 + 64'(i);
      tick();
    end
    afu_tx_valid = '0;
    fiu_rx_valid[1] = 1'b1;
    tick();
    fiu_rx_valid = '0;
    tick();
    fiu_almost_full[0] = 1'b0;
    tick();
    check("t6_pre_tx_valid", 64'(fiu_tx_valid[0]), 64'd1);
    check("t6_pre_rx_valid", 64'(afu_rx_valid[1]), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_tx_valid", 64'(fiu_tx_valid), 64'd0);
    check("t6_rst_rx_valid", 64'(afu_rx_valid), 64'd0);
    check("t6_rst_hwm", 64'(hwm), 64'd0);
    check("t6_rst_ovf", 64'(error_overflow), 64'd0);
    check("t6_rst_afu_af", 64'(afu_almost_full), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("t6_no_stale_tx", 64'(fiu_tx_valid), 64'd0);
      check("t6_no_stale_rx", 64'(afu_rx_valid), 64'd0);
      tick();
    end
    check("t6_post_hwm", 64'(hwm), 64'd0);
    check("t6_post_ovf", 64'(error_overflow), 64'd0);
    single_c0("t6_recover", 64'hFEED_0000_0000_0006);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
